cpu_lsu: RTL and testbench

Parametrised load/store bus master for the CPU core. It replaces the fixed single-beat 32-bit load/store path with one engine that is generic in data width. It splits misaligned accesses into two aligned bus beats, sign- or zero-extends loads, and aborts stalled accesses with a timeout error. It sits between the execute stage, which issues one request at a time, and the shared bus.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_lsu_align.sv | 55 +++++
 rtl/cpu_lsu.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU load/store unit: access sizes, FSM states and size helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STB  = 2'b01,
    REL  = 2'b10
  } lsu_state_t;

  // Number of bytes covered by an access of the given size.
  function automatic logic [3:0] size_bytes(input lsu_size_t s);
    return 4'(1) << s;
  endfunction

  // An access is legal when it fits in one bus word.
  function automatic logic size_legal(input lsu_size_t s, input int unsigned bytes);
    return 32'(size_bytes(s)) <= bytes;
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Lane math for the load/store unit: two-beat byte masks and store data placement,
// plus extraction and sign/zero extension of the load result.
module cpu_lsu_align
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  lsu_size_t                   size,
  input  logic                        sgn,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [2*DATA_W-1:0]         rwin,
  output logic [DATA_W/8-1:0]         mask0_c,
  output logic [DATA_W/8-1:0]         mask1_c,
  output logic [DATA_W-1:0]           wdat0_c,
  output logic [DATA_W-1:0]           wdat1_c,
  output logic [DATA_W-1:0]           rdata_c
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned WIN_B = 2 * BYTES;
  localparam int unsigned WIN_W = 2 * DATA_W;

  logic [3:0]        nb;
  logic [WIN_B-1:0]  mask_win;
  logic [WIN_W-1:0]  wdat_win;
  logic [DATA_W-1:0] wdata_m;
  logic [DATA_W-1:0] rd_shift;
  logic              sbit;

  // Lanes form a double-width window; beat 0 is the low half, beat 1 the high half.
  always_comb begin
    nb       = size_bytes(size);
    rd_shift = DATA_W'(rwin >> {off, 3'b000});
    wdata_m  = '0;
    sbit     = 1'b0;
    rdata_c  = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (4'(i) < nb) wdata_m[8*i +: 8] = wdata[8*i +: 8];
      if (4'(i) == nb - 4'd1) sbit = rd_shift[8*i+7];
    end
    sbit = sbit & sgn;
    for (int i = 0; i < BYTES; i++) begin
      rdata_c[8*i +: 8] = (4'(i) < nb) ? rd_shift[8*i +: 8] : {8{sbit}};
    end
    mask_win = WIN_B'((16'd1 << nb) - 16'd1) << off;
    wdat_win = WIN_W'(wdata_m) << {off, 3'b000};
  end

  assign mask0_c = mask_win[BYTES-1:0];
  assign mask1_c = mask_win[WIN_B-1:BYTES];
  assign wdat0_c = wdat_win[DATA_W-1:0];
  assign wdat1_c = wdat_win[WIN_W-1:DATA_W];

endmodule

// File: rtl/cpu_lsu.sv
// Load/store bus master: one request at a time, misaligned accesses split into
// two aligned beats, load extension, and optional per-beat ack timeout.
module cpu_lsu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_ni,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W/8-1:0] sel_o,
  output logic [DATA_W-1:0]   dat_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = TO_EN ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);

  lsu_state_t        state_q, state_d;
  logic              beat_q, beat_d;
  logic              split_q, split_d;
  lsu_size_t         size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic                stb_d, we_d, rsp_valid_d, rsp_err_d, req_ready_d;
  logic [ADDR_W-1:0]   adr_d;
  logic [BYTES-1:0]    sel_d;
  logic [DATA_W-1:0]   dat_d, rsp_rdata_d;

  lsu_size_t           req_sz;
  logic [3:0]          req_nb;
  logic [OFF_W-1:0]    req_off;
  logic                idle;
  logic [OFF_W-1:0]    al_off;
  lsu_size_t           al_size;
  logic [DATA_W-1:0]   al_wdata;
  logic [2*DATA_W-1:0] rwin;
  logic [BYTES-1:0]    mask0_c, mask1_c;
  logic [DATA_W-1:0]   wdat0_c, wdat1_c, rdata_c;

  assign req_sz  = lsu_size_t'(req_size);
  assign req_nb  = size_bytes(req_sz);
  assign req_off = req_addr[OFF_W-1:0];
  assign idle    = (state_q == IDLE);

  // Lane math follows the incoming request in IDLE, the registered one afterwards.
  assign al_off   = idle ? req_off   : off_q;
  assign al_size  = idle ? req_sz    : size_q;
  assign al_wdata = idle ? req_wdata : wdata_q;
  assign rwin     = beat_q ? {dat_i, asm_q} : {DATA_W'(0), dat_i};

  cpu_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .off     (al_off),
    .size    (al_size),
    .sgn     (sgn_q),
    .wdata   (al_wdata),
    .rwin    (rwin),
    .mask0_c (mask0_c),
    .mask1_c (mask1_c),
    .wdat0_c (wdat0_c),
    .wdat1_c (wdat1_c),
    .rdata_c (rdata_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    split_d     = split_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    stb_d       = stb_o;
    we_d        = we_o;
    adr_d       = adr_o;
    sel_d       = sel_o;
    dat_d       = dat_o;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_sz;
          sgn_d   = req_signed;
          off_d   = req_off;
          wdata_d = req_wdata;
          if (!size_legal(req_sz, BYTES)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = STB;
            beat_d  = 1'b0;
            cnt_d   = '0;
            split_d = (5'(req_off) + 5'(req_nb)) > 5'(BYTES);
            stb_d   = 1'b1;
            we_d    = req_we;
            adr_d   = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            sel_d   = mask0_c;
            dat_d   = wdat0_c;
          end
        end
      end
      STB: begin
        if (ack_i) begin
          stb_d   = 1'b0;
          state_d = REL;
          if (!beat_q) asm_d = dat_i;
          if (beat_q || !split_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_o ? '0 : rdata_c;
          end
        end else if (TO_EN && cnt_q == CNT_MAX) begin
          // Abort: drop the strobe and skip any remaining beat.
          stb_d       = 1'b0;
          state_d     = REL;
          split_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REL: begin
        if (!ack_i) begin
          if (split_q && !beat_q) begin
            state_d = STB;
            beat_d  = 1'b1;
            cnt_d   = '0;
            stb_d   = 1'b1;
            adr_d   = adr_o + ADDR_W'(BYTES);
            sel_d   = mask1_c;
            dat_d   = wdat1_c;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      beat_q    <= 1'b0;
      split_q   <= 1'b0;
      size_q    <= BYTE;
      sgn_q     <= 1'b0;
      off_q     <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      cnt_q     <= '0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      sel_o     <= '0;
      dat_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      split_q   <= split_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      stb_o     <= stb_d;
      we_o      <= we_d;
      adr_o     <= adr_d;
      sel_o     <= sel_d;
      dat_o     <= dat_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      req_ready <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_cpu_lsu.sv
// Scoreboard bench for cpu_lsu (32-bit bus, TIMEOUT=8): expected beats and responses
// are queued as requests are issued and checked as the bus and response port produce them.
module tb_cpu_lsu;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              stb_o, we_o, ack_i;
  logic [ADDR_W-1:0] adr_o;
  logic [3:0]        sel_o;
  logic [DATA_W-1:0] dat_o, dat_i;

  cpu_lsu #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .sel_o      (sel_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] slv_data_q[$];
  int          slv_wait;
  bit          slv_mute;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_beat(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                          input logic [31:0] dat);
    beat_t b;
    b.adr = adr; b.sel = sel; b.we = we; b.dat = dat;
    beat_q.push_back(b);
  endtask

  task automatic exp_rsp(input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.rdata = rdata; r.err = err;
    rsp_q.push_back(r);
  endtask

  // Drive one request; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'(1));
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", 32'(rsp_q.size() == 0 && req_ready), 32'(1));
    chk("beats_consumed", 32'(beat_q.size()), 32'(0));
  endtask

  // Bus slave: checks each new strobe against the expected beat, acks after slv_wait cycles.
  initial begin : slave
    bit          seen;
    int          wcnt;
    beat_t       e;
    logic [31:0] held_adr;
    logic [3:0]  held_sel;
    seen = 1'b0; wcnt = 0; held_adr = '0; held_sel = '0;
    ack_i = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk);
      if (!stb_o) seen = 1'b0;
      if (ack_i) begin
        ack_i = 1'b0;
        dat_i = '0;
      end else if (stb_o) begin
        if (!seen) begin
          seen = 1'b1; wcnt = 0; held_adr = adr_o; held_sel = sel_o;
          chk("beat_expected", 32'(beat_q.size() != 0), 32'(1));
          if (beat_q.size() != 0) begin
            e = beat_q.pop_front();
            chk("beat_adr", adr_o, e.adr);
            chk("beat_sel", 32'(sel_o), 32'(e.sel));
            chk("beat_we", 32'(we_o), 32'(e.we));
            if (e.we) chk("beat_dat", dat_o, e.dat);
          end
        end else begin
          chk("adr_stable", adr_o, held_adr);
          chk("sel_stable", 32'(sel_o), 32'(held_sel));
        end
        if (!slv_mute) begin
          if (wcnt == slv_wait) begin
            ack_i = 1'b1;
            dat_i = (slv_data_q.size() != 0) ? slv_data_q.pop_front() : '0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("rsp_expected", 32'(rsp_q.size() != 0), 32'(1));
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    n_chk = 0; n_fail = 0; slv_wait = 0; slv_mute = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_stb", 32'(stb_o), 32'(0));
    chk("rst_we", 32'(we_o), 32'(0));
    chk("rst_adr", adr_o, 32'(0));
    chk("rst_sel", 32'(sel_o), 32'(0));
    chk("rst_dat", dat_o, 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_rsp_rdata", rsp_rdata, 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    // Word load, two wait states.
    slv_wait = 2;
    exp_beat(32'h100, 4'b1111, 1'b0, '0);
    slv_data_q.push_back(32'hDEADBEEF);
    exp_rsp(32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h100, '0);
    wait_done();

    // Byte load at top lane, signed then unsigned.
    slv_wait = 1;
    exp_beat(32'h100, 4'b1000, 1'b0, '0);
    slv_data_q.push_back(32'h80000000);
    exp_rsp(32'hFFFFFF80, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h103, '0);
    wait_done();
    exp_beat(32'h100, 4'b1000, 1'b0, '0);
    slv_data_q.push_back(32'h80000000);
    exp_rsp(32'h00000080, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h103, '0);
    wait_done();

    // Aligned latency: stb in cycle 1, rsp in cycle 2, ready in cycle 3.
    slv_wait = 0;
    exp_beat(32'h100, 4'b1100, 1'b0, '0);
    slv_data_q.push_back(32'h80010000);
    exp_rsp(32'hFFFF8001, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h102, '0);
    @(negedge clk);
    chk("c1_stb", 32'(stb_o), 32'(1));
    chk("c1_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    chk("c2_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("c2_stb", 32'(stb_o), 32'(0));
    chk("c2_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    chk("c3_ready", 32'(req_ready), 32'(1));
    wait_done();

    // Misaligned word store: two beats, response two cycles later than aligned.
    slv_wait = 0;
    exp_beat(32'h100, 4'b1100, 1'b1, 32'h33440000);
    exp_beat(32'h104, 4'b0011, 1'b1, 32'h00001122);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    chk("split_rsp_cycle", 32'(n), 32'(4));
    wait_done();

    // Misaligned half load across a word boundary.
    slv_wait = 1;
    exp_beat(32'h1FC, 4'b1000, 1'b0, '0);
    exp_beat(32'h200, 4'b0001, 1'b0, '0);
    slv_data_q.push_back(32'hAB000000);
    slv_data_q.push_back(32'h000000CD);
    exp_rsp(32'h0000CDAB, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h1FF, '0);
    wait_done();

    // Timeout on beat 0 of a split load; beat 1 must never appear.
    slv_mute = 1'b1;
    exp_beat(32'h1FC, 4'b1000, 1'b0, '0);
    exp_rsp(32'h0, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h1FF, '0);
    n = 0;
    @(negedge clk);
    while (stb_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_len", 32'(n), 32'(TIMEOUT));
    wait_done();
    repeat (4) @(negedge clk);
    slv_mute = 1'b0;

    // Illegal dword on a 32-bit bus: error in cycle 1, no strobe.
    exp_rsp(32'h0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h55AA55AA);
    @(negedge clk);
    chk("ill_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("ill_rsp_err", 32'(rsp_err), 32'(1));
    chk("ill_stb", 32'(stb_o), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ill_no_stb", 32'(stb_o), 32'(0));
    end
    wait_done();

    // Reset in the middle of a strobe: no response, then a normal access.
    slv_mute = 1'b1;
    exp_beat(32'h200, 4'b1111, 1'b0, '0);
    issue(1'b0, 2'b10, 1'b0, 32'h200, '0);
    @(negedge clk);
    chk("pre_rst_stb", 32'(stb_o), 32'(1));
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_stb", 32'(stb_o), 32'(0));
    chk("async_rst_rsp", 32'(rsp_valid), 32'(0));
    chk("async_rst_ready", 32'(req_ready), 32'(1));
    @(negedge clk);
    rst_ni = 1'b1;
    slv_mute = 1'b0;
    repeat (2) @(negedge clk);
    exp_beat(32'h300, 4'b1111, 1'b1, 32'hCAFEF00D);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D);
    wait_done();

    repeat (5) @(negedge clk);
    chk("final_rsp_q", 32'(rsp_q.size()), 32'(0));
    chk("final_beat_q", 32'(beat_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
